spi_adc_req_arbiter: RTL and testbench
======================================

Name: spi_adc_req_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one SPI_Master_With_Single_CS instance (mode 3, 2 bytes per CS) among NUM_REQ requesters, each reading one channel of a multi-channel 8-channel SPI ADC. For a granted request it issues a 2-byte CS frame with the channel address in byte 0, packs the two received bytes into a 16-bit word and returns it tagged with the requester index. It sits between the sensor-processing logic and the SPI master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index, equals clog2(NUM_REQ), minimum 1
TIMEOUT_CLKS, 4096, max clocks from first TX_DV to second RX_DV before abort

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  synchronous reset, active high
i_Req  in  NUM_REQ  level request per requester
i_Req_Chan  in  3*NUM_REQ  channel for requester k at bits [3k+2:3k]
o_Rsp_DV  out  1  one-cycle response strobe
o_Rsp_Id  out  ID_W  requester served
o_Rsp_Word  out  16  {RX byte0, RX byte1}
o_Rsp_Err  out  1  valid with o_Rsp_DV: 1 = timeout abort, o_Rsp_Word = 0
o_Busy  out  1  high when not in IDLE
o_SPI_TX_Count  out  2  constant 2'b10
o_SPI_TX_Byte  out  8  byte to master
o_SPI_TX_DV  out  1  one-cycle byte strobe to master
i_SPI_TX_Ready  in  1  master ready for byte
i_SPI_RX_Count  in  2  index of received byte
i_SPI_RX_DV  in  1  received-byte strobe
i_SPI_RX_Byte  in  8  received byte

Behaviour:
- Single clock i_Clk; synchronous active-high i_Rst. Reset: state IDLE, o_Rsp_DV=0, o_Rsp_Id=0, o_Rsp_Word=0, o_Rsp_Err=0, o_SPI_TX_DV=0, o_SPI_TX_Byte=0, RR pointer=0, timeout counter=0.
- Requester handshake: hold i_Req[k] high and channel stable until o_Rsp_DV with o_Rsp_Id=k; may drop next cycle. Request dropped before grant: ignored. Request dropped after grant: transaction still completes and responds.
- States: IDLE, SEND0, WAIT1, SEND1, WAIT_RX, RESP.
- IDLE: if any i_Req bit set, grant the first set bit at or after RR pointer (wrapping modulo NUM_REQ). Latch id and channel. Set pointer = (id+1) mod NUM_REQ. Go to SEND0. Grant decision takes 1 cycle.
- SEND0: when i_SPI_TX_Ready=1, pulse o_SPI_TX_DV for 1 cycle with o_SPI_TX_Byte = {2'b00, chan, 3'b000}. Clear the timeout counter and go to WAIT1.
- WAIT1: wait 1 cycle for master Ready to drop. Then go to SEND1.
- SEND1: when i_SPI_TX_Ready=1, pulse o_SPI_TX_DV with byte 8'h00. Go to WAIT_RX.
- RX capture runs in SEND1 and WAIT_RX: i_SPI_RX_DV with RX_Count=0 stores byte0; RX_DV with RX_Count=1 stores byte1 and moves to RESP. RX_DV in any other state is ignored.
- RESP: o_Rsp_DV=1 for exactly one cycle, with o_Rsp_Id, o_Rsp_Word and o_Rsp_Err=0. Then go to IDLE. The next grant can occur the cycle after RESP.
- o_SPI_TX_DV is never asserted while i_SPI_TX_Ready=0. It is never high two consecutive cycles.
- Timeout: the counter increments every cycle in WAIT1, SEND1 and WAIT_RX. When it reaches TIMEOUT_CLKS-1, go to RESP with o_Rsp_Err=1 and o_Rsp_Word=0. The master is not reset; the next SEND0 waits on i_SPI_TX_Ready.
- i_Rst asserted mid-transaction: return to reset state next cycle. No response is issued for the in-flight request.
- o_Busy = (state != IDLE).
- Outputs o_Rsp_* hold their values between strobes.

Test Plan:
- Single request: i_Req=4'b0001, chan0=3'd5, slave returns 0x0A then 0xBC -> TX bytes 0x28 then 0x00, one CS frame, o_Rsp_DV with Id=0, Word=0x0ABC, Err=0.
- All four requesting continuously -> grants in order 0,1,2,3,0; each Id appears once per 4 responses; no TX_DV while Ready=0.
- Fairness/wrap: last grant Id=2, i_Req=4'b0101 -> next grant is 0 (pointer=3, wraps past 3), then 2.
- Timeout: TIMEOUT_CLKS=64, slave never returns byte1 -> o_Rsp_DV at 64 clocks after first TX_DV, Err=1, Word=0; next request is served normally.
- Reset mid-frame: assert i_Rst in WAIT_RX -> next cycle o_Busy=0, TX_DV=0, no o_Rsp_DV; a later request completes correctly.
- Request drop after grant: i_Req[1] falls in SEND1 -> response for Id=1 still issued once, no regrant.

Source files
------------

// File: rtl/spi_adc_req_arbiter.sv
// spi_adc_req_arbiter
// Shares one SPI master (mode 3, two bytes per chip-select) among NUM_REQ
// requesters. Each requester reads one channel of an 8-channel SPI ADC.
// Grants are round-robin. A granted request sends a two-byte frame with the
// channel address in byte 0. The two returned bytes are packed into a 16-bit
// word and tagged with the requester index.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no transaction; pick the next requester round-robin
// S_SEND0   | wait for master ready, strobe the channel address byte
// S_WAIT1   | one cycle for master ready to fall after the first strobe
// S_SEND1   | wait for master ready, strobe the dummy byte; capture RX
// S_WAIT_RX | wait for the second received byte; capture RX
// S_RESP    | response strobe cycle, then back to idle
//
// The timeout counter is cleared when byte 0 is strobed. It then counts every
// cycle in S_WAIT1, S_SEND1 and S_WAIT_RX. If it reaches TIMEOUT_CLKS-1, the
// transaction is aborted with an error response.
// The master itself is not reset on a timeout, so the next S_SEND0 still waits
// for ready.

module spi_adc_req_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int TIMEOUT_CLKS = 4096
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic [NUM_REQ-1:0]     i_Req,
   input  logic [3*NUM_REQ-1:0]   i_Req_Chan,
   output logic                   o_Rsp_DV,
   output logic [ID_W-1:0]        o_Rsp_Id,
   output logic [15:0]            o_Rsp_Word,
   output logic                   o_Rsp_Err,
   output logic                   o_Busy,
   output logic [1:0]             o_SPI_TX_Count,
   output logic [7:0]             o_SPI_TX_Byte,
   output logic                   o_SPI_TX_DV,
   input  logic                   i_SPI_TX_Ready,
   input  logic [1:0]             i_SPI_RX_Count,
   input  logic                   i_SPI_RX_DV,
   input  logic [7:0]             i_SPI_RX_Byte
);

   localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND0,
      S_WAIT1,
      S_SEND1,
      S_WAIT_RX,
      S_RESP
   } state_t;

   state_t            state_q;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   id_q;
   logic [2:0]        chan_q;
   logic [7:0]        b0_q;
   logic [CNT_W-1:0]  tmo_q;
   logic              rsp_dv_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [15:0]       rsp_word_q;
   logic              rsp_err_q;
   logic              tx_dv_q;
   logic [7:0]        tx_byte_q;

   logic [2:0]        chan_a [NUM_REQ];
   logic              gnt_vld_d;
   logic [ID_W-1:0]   gnt_id_d;
   logic [ID_W-1:0]   ptr_d;
   logic [ID_W:0]     rr_sum;
   logic              rx_on;
   logic              rx_b0;
   logic              rx_b1;
   logic              tmo_hit;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_chan
      assign chan_a[k] = i_Req_Chan[3*k +: 3];
   end

   // Round-robin pick: scan offsets from high to low so the smallest offset
   // from the pointer is the last one written and therefore wins.
   always_comb begin
      gnt_vld_d = 1'b0;
      gnt_id_d  = '0;
      rr_sum    = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         rr_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (rr_sum >= (ID_W+1)'(NUM_REQ)) begin
            rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
         end
         if (i_Req[rr_sum[ID_W-1:0]]) begin
            gnt_vld_d = 1'b1;
            gnt_id_d  = rr_sum[ID_W-1:0];
         end
      end
      ptr_d = (gnt_id_d == ID_W'(NUM_REQ-1)) ? '0 : gnt_id_d + ID_W'(1);
   end

   assign rx_on   = (state_q == S_SEND1) || (state_q == S_WAIT_RX);
   assign rx_b0   = i_SPI_RX_DV && (i_SPI_RX_Count == 2'd0);
   assign rx_b1   = i_SPI_RX_DV && (i_SPI_RX_Count == 2'd1);
   assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CLKS-1));

   // Transaction sequencer with registered SPI and response outputs.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         chan_q     <= '0;
         b0_q       <= '0;
         tmo_q      <= '0;
         rsp_dv_q   <= 1'b0;
         rsp_id_q   <= '0;
         rsp_word_q <= '0;
         rsp_err_q  <= 1'b0;
         tx_dv_q    <= 1'b0;
         tx_byte_q  <= '0;
      end else begin
         tx_dv_q  <= 1'b0;
         rsp_dv_q <= 1'b0;
         if (rx_on && rx_b0) begin
            b0_q <= i_SPI_RX_Byte;
         end
         case (state_q)
            S_IDLE: begin
               if (gnt_vld_d) begin
                  id_q    <= gnt_id_d;
                  chan_q  <= chan_a[gnt_id_d];
                  ptr_q   <= ptr_d;
                  state_q <= S_SEND0;
               end
            end
            S_SEND0: begin
               if (i_SPI_TX_Ready) begin
                  tx_dv_q   <= 1'b1;
                  tx_byte_q <= {2'b00, chan_q, 3'b000};
                  tmo_q     <= '0;
                  state_q   <= S_WAIT1;
               end
            end
            S_WAIT1, S_SEND1, S_WAIT_RX: begin
               if (rx_on && rx_b1) begin
                  rsp_dv_q   <= 1'b1;
                  rsp_id_q   <= id_q;
                  rsp_word_q <= {b0_q, i_SPI_RX_Byte};
                  rsp_err_q  <= 1'b0;
                  state_q    <= S_RESP;
               end else if (tmo_hit) begin
                  rsp_dv_q   <= 1'b1;
                  rsp_id_q   <= id_q;
                  rsp_word_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state_q    <= S_RESP;
               end else begin
                  tmo_q <= tmo_q + CNT_W'(1);
                  if (state_q == S_WAIT1) begin
                     state_q <= S_SEND1;
                  end else if ((state_q == S_SEND1) && i_SPI_TX_Ready) begin
                     tx_dv_q   <= 1'b1;
                     tx_byte_q <= 8'h00;
                     state_q   <= S_WAIT_RX;
                  end
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_Rsp_DV       = rsp_dv_q;
   assign o_Rsp_Id       = rsp_id_q;
   assign o_Rsp_Word     = rsp_word_q;
   assign o_Rsp_Err      = rsp_err_q;
   assign o_Busy         = (state_q != S_IDLE);
   assign o_SPI_TX_Count = 2'b10;
   assign o_SPI_TX_Byte  = tx_byte_q;
   assign o_SPI_TX_DV    = tx_dv_q;

endmodule

// File: tb/tb_spi_adc_req_arbiter.sv
// Bench for spi_adc_req_arbiter: behavioural SPI master/ADC slave plus a
// transaction-level round-robin model. Expected grant order comes from the
// request vector and a model pointer. Expected words come from the ADC
// contents of the channel the model expects.

module tb_spi_adc_req_arbiter;

   localparam int NR = 4;
   localparam int IW = 2;
   localparam int TO = 64;

   logic            i_Clk;
   logic            i_Rst;
   logic [NR-1:0]   i_Req;
   logic [3*NR-1:0] i_Req_Chan;
   logic            o_Rsp_DV;
   logic [IW-1:0]   o_Rsp_Id;
   logic [15:0]     o_Rsp_Word;
   logic            o_Rsp_Err;
   logic            o_Busy;
   logic [1:0]      o_SPI_TX_Count;
   logic [7:0]      o_SPI_TX_Byte;
   logic            o_SPI_TX_DV;
   logic            i_SPI_TX_Ready;
   logic [1:0]      i_SPI_RX_Count;
   logic            i_SPI_RX_DV;
   logic [7:0]      i_SPI_RX_Byte;

   spi_adc_req_arbiter #(
      .NUM_REQ      (NR),
      .ID_W         (IW),
      .TIMEOUT_CLKS (TO)
   ) dut (
      .i_Clk          (i_Clk),
      .i_Rst          (i_Rst),
      .i_Req          (i_Req),
      .i_Req_Chan     (i_Req_Chan),
      .o_Rsp_DV       (o_Rsp_DV),
      .o_Rsp_Id       (o_Rsp_Id),
      .o_Rsp_Word     (o_Rsp_Word),
      .o_Rsp_Err      (o_Rsp_Err),
      .o_Busy         (o_Busy),
      .o_SPI_TX_Count (o_SPI_TX_Count),
      .o_SPI_TX_Byte  (o_SPI_TX_Byte),
      .o_SPI_TX_DV    (o_SPI_TX_DV),
      .i_SPI_TX_Ready (i_SPI_TX_Ready),
      .i_SPI_RX_Count (i_SPI_RX_Count),
      .i_SPI_RX_DV    (i_SPI_RX_DV),
      .i_SPI_RX_Byte  (i_SPI_RX_Byte)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int          m_ptr;
   logic [2:0]  cur_chan [NR];
   logic [15:0] adc_mem [8];
   bit          exp_vld;
   int          exp_id;
   logic [2:0]  exp_chan;
   bit          drop_b1;

   // slave / monitor state
   int          cyc;
   int          rx_cnt;
   int          rdy_cnt;
   bit          rx_pend;
   logic [1:0]  rx_idx_p;
   logic [7:0]  rx_byte_p;
   logic [2:0]  sl_chan;
   int          tx_n;
   int          first_tx_cyc;
   bit          prev_tx;
   bit          rsp_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         int k;
         k = (m_ptr + i) % NR;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic slave_clear();
      rx_cnt         = 0;
      rdy_cnt        = 0;
      rx_pend        = 0;
      prev_tx        = 0;
      i_SPI_TX_Ready = 1'b1;
      i_SPI_RX_DV    = 1'b0;
   endtask

   // One clock: advance, then act as SPI master/slave and monitor responses.
   task automatic step();
      @(posedge i_Clk);
      #1;
      cyc++;
      i_SPI_RX_DV = 1'b0;
      if (o_SPI_TX_DV) begin
         chk("tx_while_ready", i_SPI_TX_Ready, 1);
         chk("tx_back_to_back", prev_tx, 0);
         tx_n++;
         if (tx_n == 1) begin
            first_tx_cyc = cyc;
            chk("tx_byte0", o_SPI_TX_Byte, {2'b00, exp_chan, 3'b000});
            sl_chan   = o_SPI_TX_Byte[5:3];
            rx_pend   = 1;
            rx_idx_p  = 2'd0;
            rx_byte_p = adc_mem[sl_chan][15:8];
         end else begin
            chk("tx_byte1", o_SPI_TX_Byte, 0);
            rx_pend   = !drop_b1;
            rx_idx_p  = 2'd1;
            rx_byte_p = adc_mem[sl_chan][7:0];
         end
         i_SPI_TX_Ready = 1'b0;
         rx_cnt  = $urandom_range(2, 6);
         rdy_cnt = 0;
      end else if (rx_cnt > 0) begin
         rx_cnt--;
         if (rx_cnt == 0) begin
            if (rx_pend) begin
               i_SPI_RX_DV    = 1'b1;
               i_SPI_RX_Count = rx_idx_p;
               i_SPI_RX_Byte  = rx_byte_p;
            end
            rx_pend = 0;
            rdy_cnt = $urandom_range(1, 3);
         end
      end else if (rdy_cnt > 0) begin
         rdy_cnt--;
         if (rdy_cnt == 0) i_SPI_TX_Ready = 1'b1;
      end
      prev_tx = o_SPI_TX_DV;
      if (o_Rsp_DV) begin
         if (!exp_vld) begin
            chk("rsp_unexpected", o_Rsp_DV, 0);
         end else begin
            chk("rsp_id", o_Rsp_Id, exp_id);
            chk("rsp_err", o_Rsp_Err, drop_b1);
            chk("rsp_word", o_Rsp_Word, drop_b1 ? 16'h0000 : adc_mem[exp_chan]);
            chk("rsp_tx_count", tx_n, 2);
            if (drop_b1) chk("timeout_latency", cyc - first_tx_cyc, TO);
         end
         exp_vld  = 0;
         rsp_seen = 1;
      end
   endtask

   task automatic set_req(input logic [NR-1:0] v, input logic [NR-1:0] held);
      for (int k = 0; k < NR; k++) begin
         if (v[k] && !held[k]) cur_chan[k] = 3'($urandom_range(0, 7));
      end
      for (int c = 0; c < 8; c++) adc_mem[c] = 16'($urandom);
      i_Req      = v;
      i_Req_Chan = {cur_chan[3], cur_chan[2], cur_chan[1], cur_chan[0]};
      tx_n       = 0;
      if (v != '0) begin
         exp_id   = rr_pick(v);
         m_ptr    = (exp_id + 1) % NR;
         exp_chan = cur_chan[exp_id];
         exp_vld  = 1;
      end else begin
         exp_vld = 0;
      end
   endtask

   task automatic run_until_rsp(input string tag);
      rsp_seen = 0;
      for (int i = 0; i < 300 && !rsp_seen; i++) step();
      if (!rsp_seen) chk({tag, "_no_response"}, rsp_seen, 1);
   endtask

   task automatic wait_tx(input int n, input string tag);
      for (int i = 0; i < 200 && tx_n < n; i++) step();
      if (tx_n < n) chk({tag, "_tx_wait"}, tx_n, n);
   endtask

   task automatic apply_reset();
      i_Rst   = 1'b1;
      i_Req   = '0;
      exp_vld = 0;
      step();
      step();
      i_Rst = 1'b0;
      slave_clear();
      m_ptr = 0;
      tx_n  = 0;
   endtask

   initial begin
      logic [NR-1:0] held;
      logic [NR-1:0] v;
      cyc            = 0;
      drop_b1        = 0;
      i_Rst          = 1'b1;
      i_Req          = '0;
      i_Req_Chan     = '0;
      i_SPI_RX_Count = 2'd0;
      i_SPI_RX_Byte  = 8'h00;
      for (int k = 0; k < NR; k++) cur_chan[k] = 3'd0;
      for (int c = 0; c < 8; c++) adc_mem[c] = 16'h0;
      slave_clear();
      apply_reset();

      chk("rst_busy", o_Busy, 0);
      chk("rst_rsp_dv", o_Rsp_DV, 0);
      chk("rst_rsp_id", o_Rsp_Id, 0);
      chk("rst_rsp_word", o_Rsp_Word, 0);
      chk("rst_rsp_err", o_Rsp_Err, 0);
      chk("rst_tx_dv", o_SPI_TX_DV, 0);
      chk("rst_tx_byte", o_SPI_TX_Byte, 0);
      chk("tx_count_const", o_SPI_TX_Count, 2'b10);

      // single request, channel 5, ADC returns 0x0A,0xBC
      cur_chan[0] = 3'd5;
      set_req(4'b0001, 4'b0001);
      adc_mem[5] = 16'h0ABC;
      wait_tx(1, "single");
      chk("single_tx0", o_SPI_TX_Byte, 8'h28);
      run_until_rsp("single");
      chk("single_word", o_Rsp_Word, 16'h0ABC);
      set_req(4'b0000, 4'b0000);
      for (int i = 0; i < 5; i++) step();
      chk("single_idle", o_Busy, 0);
      chk("single_hold_word", o_Rsp_Word, 16'h0ABC);

      // all four requesting continuously from a fresh pointer
      apply_reset();
      set_req(4'b1111, 4'b0000);
      for (int n = 0; n < 5; n++) begin
         run_until_rsp("all4");
         if (n < 4) set_req(4'b1111, 4'b1111 & ~(4'b0001 << exp_id));
      end

      // wrap: serve 2, then {0,2} -> 0 then 2
      set_req(4'b0100, 4'b0100);
      run_until_rsp("wrap_a");
      set_req(4'b0101, 4'b0000);
      run_until_rsp("wrap_b");
      chk("wrap_first", o_Rsp_Id, 0);
      set_req(4'b0100, 4'b0100);
      run_until_rsp("wrap_c");
      chk("wrap_second", o_Rsp_Id, 2);
      set_req(4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) step();

      // request 1 dropped after grant (during SEND1)
      set_req(4'b0010, 4'b0000);
      wait_tx(1, "drop");
      step();
      i_Req = '0;
      run_until_rsp("drop");
      for (int i = 0; i < 8; i++) step();
      chk("drop_no_regrant", o_Busy, 0);

      // timeout: byte 1 never returned
      drop_b1 = 1;
      set_req(4'b1000, 4'b0000);
      run_until_rsp("timeout");
      drop_b1 = 0;
      set_req(4'b0001, 4'b0000);
      run_until_rsp("after_timeout");
      set_req(4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) step();

      // reset while waiting for the second received byte
      set_req(4'b0100, 4'b0000);
      wait_tx(2, "midrst");
      i_Rst   = 1'b1;
      i_Req   = '0;
      exp_vld = 0;
      step();
      i_Rst = 1'b0;
      chk("midrst_busy", o_Busy, 0);
      chk("midrst_tx_dv", o_SPI_TX_DV, 0);
      chk("midrst_rsp_dv", o_Rsp_DV, 0);
      slave_clear();
      m_ptr = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("midrst_no_rsp", o_Rsp_DV, 0);
      end
      set_req(4'b0100, 4'b0000);
      run_until_rsp("after_midrst");

      // randomized traffic; pending requesters always hold their request
      v = 4'($urandom_range(1, 15));
      set_req(v, 4'b0000);
      for (int n = 0; n < 150; n++) begin
         run_until_rsp("rand");
         held = i_Req & ~(4'b0001 << exp_id);
         v    = held | (4'($urandom) & 4'($urandom));
         if (v == '0) begin
            set_req(4'b0000, 4'b0000);
            for (int i = 0; i < $urandom_range(1, 4); i++) step();
            set_req(4'($urandom_range(1, 15)), 4'b0000);
         end else begin
            set_req(v, held);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
